mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer that shares one single-port, fixed-latency unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage: loads and stores) of the 5-stage pipeline. It serialises accesses, grants data first with a starvation guard for fetch, drives the memory port, and returns read data with a one-cycle done pulse. Its stall outputs feed the pipeline's freeze logic.

## Interface
- MEM_LATENCY, 2: cycles from mem_en to valid mem_rdata; legal range 1..15.
- MAX_D_STREAK, 2: consecutive data grants allowed while if_req waits; legal range 1..3.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high with stable if_addr until if_done.
- if_addr  in  32  fetch byte address.
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  32  fetched instruction; holds value until next fetch completes.
- if_stall  out  1  if_req & ~if_done (combinational).
- d_req  in  1  data request; held high with stable d_we/d_addr/d_wdata until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_done  out  1  one-cycle pulse: data access complete.
- d_rdata  out  32  load data; updated only on load completion, otherwise held.
- d_stall  out  1  d_req & ~d_done (combinational).
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  write enable, valid with mem_en.
- mem_addr  out  32  memory address, valid with mem_en.
- mem_wdata  out  32  memory write data, valid with mem_en.
- mem_rdata  in  32  memory read data, valid exactly MEM_LATENCY cycles after mem_en.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Owner register own (0 = IF, 1 = data) fixed from grant to DONE.
- IDLE: sample requests. None -> stay. Only one -> grant it. Both -> grant data unless streak >= MAX_D_STREAK, then grant IF. Grant latches addr/we/wdata into the port registers, -> ISSUE.
- Streak counter (2 bits, saturating): +1 on each data grant made while if_req=1; cleared on every IF grant and on reset.
- ISSUE: mem_en=1, mem_we = latched we (always 0 for IF), load latency counter = MEM_LATENCY-1; -> WAIT (or DONE directly's capture path if MEM_LATENCY=1, see below).
- WAIT: decrement counter each cycle; when counter reaches 0 on the cycle mem_rdata is valid, capture mem_rdata into if_rdata (owner IF) or d_rdata (owner data, load only); -> DONE.
- DONE: assert if_done or d_done per owner for exactly one cycle; requests are NOT sampled; -> IDLE.
- Stores: same sequence and latency as loads; d_rdata untouched.
- Requests deasserted before done are a protocol violation; behaviour undefined, no recovery required.

## Timing
- Request first seen high in IDLE at cycle 0 -> mem_en cycle 1 -> mem_rdata valid cycle 1+MEM_LATENCY (captured at that edge) -> done pulse cycle 2+MEM_LATENCY -> IDLE cycle 3+MEM_LATENCY. Throughput: one access per 3+MEM_LATENCY cycles.
- MEM_LATENCY=1: WAIT lasts one cycle, capture at end of it; same formula holds.
- Simultaneous requests at cycle 0: loser stays pending, granted at the first IDLE cycle after winner's DONE.
- Request arriving during ISSUE/WAIT/DONE: held, considered at next IDLE.
- Reset: all state to IDLE; mem_en, mem_we, if_done, d_done, streak = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0. Reset mid-access abandons it: no done pulse, no capture, even if mem_rdata arrives next cycle.
- mem_addr/mem_wdata/mem_we hold last value outside ISSUE; only mem_en qualifies them.

## Test plan
- Single fetch, MEM_LATENCY=2: if_req, if_addr=0x10 at cycle 0, mem_rdata=0x00500093 at cycle 3 -> mem_en cycle 1 with addr 0x10, if_done and if_rdata=0x00500093 cycle 4, if_stall high cycles 0-3.
- Store then load: d_we=1, addr 0x40, wdata 0xDEADBEEF -> mem_en&mem_we cycle 1, d_done cycle 4, d_rdata unchanged; then load 0x40 returning 0xDEADBEEF -> d_rdata=0xDEADBEEF on d_done.
- Contention: if_req and d_req held continuously with auto-reissue, MAX_D_STREAK=2 -> grant order D, D, I, D, D, I; if_done never starved beyond 2 data accesses.
- Reset during WAIT: rst at cycle 2 of a fetch -> no if_done, mem_en=0, state IDLE cycle 3; after rst drops, pending if_req re-issues cleanly.
- Latency sweep MEM_LATENCY=1 and 15: done pulse exactly at cycle 2+MEM_LATENCY, captured data matches value driven only at cycle 1+MEM_LATENCY (garbage on other cycles).
- Back-to-back request held through DONE: d_req stays high at done cycle -> no second mem_en until requester re-presents in IDLE; exactly one mem_en per done.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data requester and memory-port signal bundle
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_stall;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_stall;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_done, if_rdata, if_stall, d_done, d_rdata, d_stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_done, if_rdata, if_stall, d_done, d_rdata, d_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises fetch and data accesses onto one fixed-latency memory port
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned MAX_D_STREAK = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LATENCY - 1);
    localparam logic [1:0] STREAK_MAX = 2'(MAX_D_STREAK);

    state_e      state_q, state_d;
    logic        own_q, own_d;
    logic [1:0]  streak_q, streak_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        data_win;

    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        streak_d   = streak_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        // Data wins unless it has already taken its allowance while fetch waited.
        data_win   = bus.d_req && (!bus.if_req || (streak_q < STREAK_MAX));

        case (state_q)
            S_IDLE: begin
                if (data_win) begin
                    own_d   = 1'b1;
                    we_d    = bus.d_we;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    if (bus.if_req && (streak_q != 2'd3)) begin
                        streak_d = streak_q + 2'd1;
                    end
                    state_d = S_ISSUE;
                end else if (bus.if_req) begin
                    own_d    = 1'b0;
                    we_d     = 1'b0;
                    addr_d   = bus.if_addr;
                    streak_d = 2'd0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (!own_q) begin
                        if_rdata_d = bus.mem_rdata;
                    end else if (!we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            own_q      <= 1'b0;
            streak_q   <= 2'd0;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            streak_q   <= streak_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign bus.mem_en    = (state_q == S_ISSUE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_done   = (state_q == S_DONE) && !own_q;
    assign bus.d_done    = (state_q == S_DONE) && own_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_stall  = bus.if_req & ~bus.if_done;
    assign bus.d_stall   = bus.d_req & ~bus.d_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int LAT  = 2;
    localparam int MAXD = 2;

    typedef struct {
        int          gap;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
    } txn_t;

    logic clk;
    logic rst;

    mem_port_arbiter_if a ();
    mem_port_arbiter_if b ();
    mem_port_arbiter_if c ();

    mem_port_arbiter #(.MEM_LATENCY(LAT), .MAX_D_STREAK(MAXD)) dut_a (.clk(clk), .rst(rst), .bus(a));
    mem_port_arbiter #(.MEM_LATENCY(1),   .MAX_D_STREAK(1))    dut_b (.clk(clk), .rst(rst), .bus(b));
    mem_port_arbiter #(.MEM_LATENCY(15),  .MAX_D_STREAK(3))    dut_c (.clk(clk), .rst(rst), .bus(c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level reference: requester queues, arbiter free time, one in-flight grant.
    txn_t        if_q[$];
    txn_t        d_q[$];
    logic [31:0] mem [logic [31:0]];
    int          cyc = 0;
    int          free_at = 0;
    int          streak = 0;
    bit          rst_prev = 1'b1;
    bit          g_valid = 1'b0;
    int          g_cycle = 0;
    bit          g_own = 1'b0;
    bit          g_we = 1'b0;
    logic [31:0] g_addr = '0, g_wdata = '0, g_rdata = '0;
    int          rd_at = -1;
    logic [31:0] rd_val = '0;
    bit          if_act = 1'b0, d_act = 1'b0, d_w = 1'b0;
    logic [31:0] if_a = '0, d_a = '0, d_wd = '0;
    bit          if_done_prev = 1'b0, d_done_prev = 1'b0;
    logic [31:0] exp_addr = '0, exp_wdata = '0, exp_if_rdata = '0, exp_d_rdata = '0;
    bit          exp_we = 1'b0;
    int          n_issue = 0, n_en = 0;
    string       order_s = "";

    function automatic logic [31:0] mem_rd(input logic [31:0] ad);
        if (mem.exists(ad)) return mem[ad];
        return (ad * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit model_idle();
        return (if_q.size() == 0) && (d_q.size() == 0) && !if_act && !d_act && (cyc >= free_at);
    endfunction

    task automatic step(input bit rst_v);
        bit exp_en, exp_ifd, exp_dd;
        @(posedge clk); #1;
        cyc++;
        if (rst_prev) begin
            free_at = cyc; g_valid = 0; streak = 0;
            exp_addr = '0; exp_wdata = '0; exp_we = 0; exp_if_rdata = '0; exp_d_rdata = '0;
        end
        rst_prev = rst_v;
        if (if_done_prev) if_act = 0;
        if (d_done_prev) d_act = 0;
        if (!if_act && if_q.size() > 0) begin
            if (if_q[0].gap == 0) begin
                if_a = if_q[0].addr; void'(if_q.pop_front()); if_act = 1;
            end else if_q[0].gap = if_q[0].gap - 1;
        end
        if (!d_act && d_q.size() > 0) begin
            if (d_q[0].gap == 0) begin
                d_a = d_q[0].addr; d_w = d_q[0].we; d_wd = d_q[0].wdata;
                void'(d_q.pop_front()); d_act = 1;
            end else d_q[0].gap = d_q[0].gap - 1;
        end
        if (!rst_v && cyc >= free_at && (if_act || d_act)) begin
            g_own = d_act && (!if_act || streak < MAXD);
            g_valid = 1; g_cycle = cyc; free_at = cyc + 3 + LAT;
            if (g_own) begin
                g_addr = d_a; g_we = d_w; g_wdata = d_wd;
                if (if_act && streak < 3) streak++;
            end else begin
                g_addr = if_a; g_we = 0; streak = 0;
            end
        end
        exp_en = g_valid && (cyc == g_cycle + 1);
        if (exp_en) begin
            n_issue++;
            exp_addr = g_addr; exp_we = g_we;
            if (g_own) exp_wdata = g_wdata;
            g_rdata = mem_rd(g_addr);
            if (g_we) mem[g_addr] = g_wdata;
            rd_at = cyc + LAT; rd_val = g_rdata;
        end
        exp_ifd = g_valid && (cyc == g_cycle + 2 + LAT) && !g_own;
        exp_dd  = g_valid && (cyc == g_cycle + 2 + LAT) && g_own;
        if (exp_ifd) exp_if_rdata = g_rdata;
        if (exp_dd && !g_we) exp_d_rdata = g_rdata;

        a.if_req = if_act; a.if_addr = if_a;
        a.d_req = d_act; a.d_we = d_w; a.d_addr = d_a; a.d_wdata = d_wd;
        a.mem_rdata = (cyc == rd_at) ? rd_val : (rd_val ^ ($urandom | 32'h1));
        rst = rst_v;
        #3;
        chk("mem_en", a.mem_en, exp_en);
        chk("mem_we", a.mem_we, exp_we);
        chk("mem_addr", a.mem_addr, exp_addr);
        chk("mem_wdata", a.mem_wdata, exp_wdata);
        chk("if_done", a.if_done, exp_ifd);
        chk("d_done", a.d_done, exp_dd);
        chk("if_stall", a.if_stall, if_act && !exp_ifd);
        chk("d_stall", a.d_stall, d_act && !exp_dd);
        chk("if_rdata", a.if_rdata, exp_if_rdata);
        chk("d_rdata", a.d_rdata, exp_d_rdata);
        if (a.mem_en === 1'b1) n_en++;
        if (a.d_done === 1'b1) order_s = {order_s, "D"};
        if (a.if_done === 1'b1) order_s = {order_s, "I"};
        if_done_prev = exp_ifd; d_done_prev = exp_dd;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!model_idle() && n < budget) begin
            step(1'b0);
            n++;
        end
        chk("drain_done", model_idle(), 1'b1);
    endtask

    // Lone request on the L=1 (fetch) or L=15 (load) instance; read data valid on one cycle only.
    task automatic sweep(input bit use_c, input int lat, input logic [31:0] addr, input logic [31:0] val);
        logic        en, dn;
        logic [31:0] rd, md;
        for (int k = 0; k <= lat + 3; k++) begin
            @(posedge clk); #1;
            md = (k == lat + 1) ? val : (val ^ ($urandom | 32'h1));
            if (!use_c) begin
                b.if_req = (k <= lat + 2); b.if_addr = addr; b.mem_rdata = md;
            end else begin
                c.d_req = (k <= lat + 2); c.d_we = 1'b0; c.d_addr = addr; c.mem_rdata = md;
            end
            #3;
            if (!use_c) begin
                en = b.mem_en; dn = b.if_done; rd = b.if_rdata;
            end else begin
                en = c.mem_en; dn = c.d_done; rd = c.d_rdata;
            end
            chk($sformatf("sweep_l%0d_en", lat), en, k == 1);
            chk($sformatf("sweep_l%0d_done", lat), dn, k == lat + 2);
            if (k >= lat + 2) chk($sformatf("sweep_l%0d_rdata", lat), rd, val);
            if (!use_c && k == 0) chk("sweep_l1_stall", b.if_stall, 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1;
        a.if_req = 0; a.if_addr = '0; a.d_req = 0; a.d_we = 0; a.d_addr = '0; a.d_wdata = '0; a.mem_rdata = '0;
        b.if_req = 0; b.if_addr = '0; b.d_req = 0; b.d_we = 0; b.d_addr = '0; b.d_wdata = '0; b.mem_rdata = '0;
        c.if_req = 0; c.if_addr = '0; c.d_req = 0; c.d_we = 0; c.d_addr = '0; c.d_wdata = '0; c.mem_rdata = '0;

        step(1'b1);
        step(1'b1);
        chk("rst_b_mem_en", b.mem_en, 1'b0);
        chk("rst_c_d_rdata", c.d_rdata, 32'h0);

        // Single fetch
        mem[32'h10] = 32'h0050_0093;
        if_q.push_back('{0, 32'h10, 1'b0, 32'h0});
        drain(50);
        chk("fetch_rdata", a.if_rdata, 32'h0050_0093);

        // Store then load of the same word
        d_q.push_back('{0, 32'h40, 1'b1, 32'hDEAD_BEEF});
        d_q.push_back('{0, 32'h40, 1'b0, 32'h0});
        drain(50);
        chk("store_load_rdata", a.d_rdata, 32'hDEAD_BEEF);

        // Continuous contention with immediate re-presentation
        order_s = "";
        for (int i = 0; i < 4; i++) d_q.push_back('{0, 32'h200 + 32'(i * 4), 1'b0, 32'h0});
        for (int i = 0; i < 2; i++) if_q.push_back('{0, 32'h300 + 32'(i * 4), 1'b0, 32'h0});
        drain(100);
        n_checks++;
        assert (order_s == "DDIDDI") else begin
            n_errors++;
            $error("FAIL grant_order: observed %s expected DDIDDI", order_s);
        end

        // Reset in the WAIT phase of a fetch, then clean re-issue
        if_q.push_back('{0, 32'h80, 1'b0, 32'h0});
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        chk("rst_abandon_rdata", a.if_rdata, 32'h0);
        drain(50);
        chk("rst_reissue_rdata", a.if_rdata, mem_rd(32'h80));

        // Randomized traffic
        for (int i = 0; i < 120; i++) begin
            if_q.push_back('{int'($urandom_range(0, 4)), 32'h100 + 32'($urandom_range(0, 7) * 4), 1'b0, 32'h0});
            d_q.push_back('{int'($urandom_range(0, 4)), 32'h100 + 32'($urandom_range(0, 7) * 4),
                            1'($urandom_range(0, 1)), $urandom});
        end
        drain(5000);
        chk("mem_en_count", n_en, n_issue);

        sweep(1'b0, 1, 32'h44, 32'hA5A5_1234);
        sweep(1'b1, 15, 32'h88, 32'h1357_9BDF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
